// File: rtl/m2_mem_resp.sv
// m2_mem_resp: M2 memory-response stage; completes ALU ops and load/store accesses.
// Latency: ALU op and misaligned fault 1 cycle; memory ops 1 cycle after dmem_rvalid.
// Backpressure: stall (state != IDLE) freezes M1/M2 while an access is outstanding.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   is_a_inst, flush  M2 slot valid / kill
//   mem_op, result    op decode ([4] mem, [3] store, [2] unsigned, [1:0] size), ALU result/address
//   rd, wb_src, pc    instruction side-band, registered into wb_rd / wb_src_out / pc_out
//   dmem_rvalid/rdata/err  data-memory response
//   stall             combinational upstream freeze
//   wb_valid, wb_data writeback strobe and aligned load / pass-through data
//   fault, fault_cause  exception strobe; 01 misaligned, 10 bus error, 11 timeout
module m2_mem_resp (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_a_inst,
  input  logic [4:0]  mem_op,
  input  logic [31:0] result,
  input  logic [4:0]  rd,
  input  logic [2:0]  wb_src,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_err,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [2:0]  wb_src_out,
  output logic [31:0] pc_out,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  wait_cnt;

  // Captured instruction context for the outstanding access.
  logic [4:0]  cap_rd;
  logic [2:0]  cap_src;
  logic [31:0] cap_pc;
  logic [3:0]  cap_op;
  logic [1:0]  cap_addr;

  logic        accept;
  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign stall  = (state != IDLE);
  assign accept = (state == IDLE) && is_a_inst && !flush;

  always_comb begin
    misaligned = 1'b0;
    case (mem_op[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = result[0];
      2'b10:   misaligned = |result[1:0];
      default: misaligned = 1'b1;  // size 11 is illegal
    endcase
  end

  // Lane selection uses the captured low address bits, not the live result bus.
  always_comb begin
    ld_byte = 8'h00;
    case (cap_addr)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = cap_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_data = dmem_rdata;
    case (cap_op[1:0])
      2'b00:   ld_data = cap_op[2] ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = cap_op[2] ? {16'h0000, ld_half}   : {{16{ld_half[15]}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      cap_rd      <= 5'd0;
      cap_src     <= 3'd0;
      cap_pc      <= 32'd0;
      cap_op      <= 4'd0;
      cap_addr    <= 2'd0;
      wb_valid    <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= 32'd0;
      wb_src_out  <= 3'd0;
      pc_out      <= 32'd0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
    end else begin
      // Strobes default low; data/side-band outputs hold.
      wb_valid <= 1'b0;
      fault    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!mem_op[4]) begin
              wb_valid   <= (rd != 5'd0);
              wb_rd      <= rd;
              wb_data    <= result;
              wb_src_out <= wb_src;
              pc_out     <= pc;
            end else if (misaligned) begin
              fault       <= 1'b1;
              fault_cause <= 2'b01;
              wb_rd       <= rd;
              wb_src_out  <= wb_src;
              pc_out      <= pc;
            end else begin
              cap_rd   <= rd;
              cap_src  <= wb_src;
              cap_pc   <= pc;
              cap_op   <= mem_op[3:0];
              cap_addr <= result[1:0];
              wait_cnt <= 8'd0;
              state    <= WAIT;
            end
          end
        end

        WAIT: begin
          if (flush) begin
            // A response arriving with the flush is simply dropped; otherwise
            // the access is still in flight and must be drained.
            state <= dmem_rvalid ? IDLE : DRAIN;
          end else if (dmem_rvalid) begin
            state      <= IDLE;
            wb_rd      <= cap_rd;
            wb_src_out <= cap_src;
            pc_out     <= cap_pc;
            if (dmem_err) begin
              fault       <= 1'b1;
              fault_cause <= 2'b10;
            end else if (!cap_op[3]) begin
              wb_data  <= ld_data;
              wb_valid <= (cap_rd != 5'd0);
            end
          end else if (wait_cnt == 8'd254) begin
            // 255th empty wait cycle: counter saturates, access is abandoned.
            wait_cnt    <= 8'd255;
            fault       <= 1'b1;
            fault_cause <= 2'b11;
            wb_rd       <= cap_rd;
            wb_src_out  <= cap_src;
            pc_out      <= cap_pc;
            state       <= DRAIN;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        DRAIN: begin
          // The late response still belongs to the abandoned access; swallow it.
          if (dmem_rvalid) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m2_mem_resp.sv
module tb_m2_mem_resp;

  logic        clk;
  logic        rst;
  logic        is_a_inst;
  logic [4:0]  mem_op;
  logic [31:0] result;
  logic [4:0]  rd;
  logic [2:0]  wb_src;
  logic [31:0] pc;
  logic        flush;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        dmem_err;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  wb_src_out;
  logic [31:0] pc_out;
  logic        fault;
  logic [1:0]  fault_cause;

  m2_mem_resp dut (
    .clk(clk), .rst(rst), .is_a_inst(is_a_inst), .mem_op(mem_op), .result(result),
    .rd(rd), .wb_src(wb_src), .pc(pc), .flush(flush), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .dmem_err(dmem_err), .stall(stall), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_src_out(wb_src_out), .pc_out(pc_out),
    .fault(fault), .fault_cause(fault_cause)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          is_fault;
    logic [1:0]  cause;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  src;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    logic [31:0] t;
    t = $urandom;
    is_a_inst   = 1'b0;
    flush       = 1'b0;
    mem_op      = t[4:0];
    result      = $urandom;
    rd          = t[9:5];
    wb_src      = t[12:10];
    pc          = $urandom;
    dmem_rvalid = 1'b0;
    dmem_rdata  = $urandom;
    dmem_err    = t[13];
  endtask

  // Reference load alignment: shift the word down to the addressed lane,
  // mask to the access size, then sign-extend numerically.
  function automatic logic [31:0] exp_load(input logic [4:0] op, input logic [1:0] a, input logic [31:0] w);
    longint v;
    int     sh;
    v  = w;
    sh = a;
    if (op[1:0] == 2'b00) begin
      v = (v >> (8 * sh)) & 64'hFF;
      if (!op[2] && v >= 128) v = v - 256;
    end else if (op[1:0] == 2'b01) begin
      v = (v >> (16 * (sh / 2))) & 64'hFFFF;
      if (!op[2] && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  function automatic exp_t mk(input bit f, input logic [1:0] c, input logic [4:0] r,
                              input logic [31:0] d, input logic [2:0] s, input logic [31:0] p);
    exp_t e;
    e.is_fault = f; e.cause = c; e.rd = r; e.data = d; e.src = s; e.pc = p;
    return e;
  endfunction

  // Issue one instruction. d = empty response cycles before rvalid,
  // flush_at = WAIT/DRAIN cycle (1-based) in which flush is raised, 0 = never.
  task automatic issue(input logic [4:0] op, input logic [31:0] addr, input logic [4:0] r,
                       input logic [2:0] src, input logic [31:0] p, input int d,
                       input logic [31:0] rdata, input logic err, input int flush_at,
                       input logic stray);
    int  sz;
    bit  mis;
    sz  = op[1:0];
    mis = (sz == 3) || (sz == 1 && addr % 2 != 0) || (sz == 2 && addr % 4 != 0);
    is_a_inst   = 1'b1;
    flush       = 1'b0;
    mem_op      = op;
    result      = addr;
    rd          = r;
    wb_src      = src;
    pc          = p;
    dmem_rvalid = stray;   // must be ignored in the capture cycle
    dmem_rdata  = $urandom;
    dmem_err    = 1'b0;
    if (!op[4]) begin
      if (r != 5'd0) q.push_back(mk(1'b0, 2'b00, r, addr, src, p));
      step();
      idle_inputs();
      chk("alu_no_stall", stall, 1'b0);
      return;
    end
    if (mis) begin
      q.push_back(mk(1'b1, 2'b01, r, 32'd0, src, p));
      step();
      idle_inputs();
      chk("misaligned_no_stall", stall, 1'b0);
      return;
    end
    step();
    idle_inputs();
    for (int c = 1; c <= d + 1; c++) begin
      chk("stall_busy", stall, 1'b1);
      flush = (c == flush_at);
      if (c == 255 && flush_at == 0 && d >= 255)
        q.push_back(mk(1'b1, 2'b11, r, 32'd0, src, p));
      if (c == d + 1) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        dmem_err    = err;
        if (flush_at == 0 && d < 255) begin
          if (err) q.push_back(mk(1'b1, 2'b10, r, 32'd0, src, p));
          else if (!op[3] && r != 5'd0) q.push_back(mk(1'b0, 2'b00, r, exp_load(op, addr[1:0], rdata), src, p));
        end
      end
      step();
      idle_inputs();
    end
    chk("stall_released", stall, 1'b0);
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid && fault) begin
        errors++;
        $display("FAIL strobe_exclusive: wb_valid=%0b fault=%0b both set", wb_valid, fault);
      end else if (wb_valid || fault) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: wb_valid=%0b fault=%0b cause=%0d with nothing expected",
                   wb_valid, fault, fault_cause);
        end else begin
          e = q.pop_front();
          chk("event_kind", fault, e.is_fault);
          chk("pc_out", pc_out, e.pc);
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_src_out", wb_src_out, e.src);
          if (e.is_fault) chk("fault_cause", fault_cause, e.cause);
          else            chk("wb_data", wb_data, e.data);
        end
      end
    end
  end

  initial begin
    logic [31:0] t;
    logic [31:0] a;
    logic [4:0]  op;
    int          d;
    int          fa;

    rst = 1'b1;
    idle_inputs();
    repeat (3) step();
    chk("rst_stall", stall, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_rd", wb_rd, 5'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_src_out", wb_src_out, 3'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_fault_cause", fault_cause, 2'b00);
    rst = 1'b0;
    step();

    // ALU pass-through
    issue(5'b00000, 32'h0000_1234, 5'd5, 3'd2, 32'h0000_0100, 0, 32'd0, 1'b0, 0, 1'b0);
    // LB / LBU at byte 3, three empty cycles then response
    issue(5'b10000, 32'h1000_0003, 5'd6, 3'd1, 32'h0000_0104, 3, 32'h80FF_FFFF, 1'b0, 0, 1'b1);
    issue(5'b10100, 32'h1000_0003, 5'd7, 3'd1, 32'h0000_0108, 3, 32'h80FF_FFFF, 1'b0, 0, 1'b0);
    // LW misaligned
    issue(5'b10010, 32'h1000_0002, 5'd8, 3'd1, 32'h0000_010C, 0, 32'd0, 1'b0, 0, 1'b0);
    // LW timeout: fault after 255 empty cycles, response in cycle 300
    issue(5'b10010, 32'h1000_0010, 5'd9, 3'd1, 32'h0000_0110, 299, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    // LH flushed in WAIT cycle 2, response cycle 5
    issue(5'b10001, 32'h1000_0002, 5'd10, 3'd1, 32'h0000_0114, 4, 32'h1234_5678, 1'b0, 2, 1'b0);
    // Flush together with the response
    issue(5'b10001, 32'h1000_0000, 5'd10, 3'd1, 32'h0000_0118, 2, 32'h1234_5678, 1'b0, 3, 1'b0);
    // SW with bus error
    issue(5'b11010, 32'h1000_0020, 5'd11, 3'd3, 32'h0000_011C, 1, 32'd0, 1'b1, 0, 1'b0);
    // Load to x0 completes without writeback; LHU upper half
    issue(5'b10010, 32'h1000_0024, 5'd0, 3'd1, 32'h0000_0120, 2, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
    issue(5'b10101, 32'h1000_0026, 5'd12, 3'd1, 32'h0000_0124, 0, 32'h8765_4321, 1'b0, 0, 1'b0);

    // Instruction flushed in IDLE is ignored
    is_a_inst = 1'b1; flush = 1'b1; mem_op = 5'b10010; result = 32'h40; rd = 5'd3;
    step();
    idle_inputs();
    chk("flush_idle_no_stall", stall, 1'b0);

    // Reset mid-WAIT overrides flush and rvalid
    issue(5'b00000, 32'hA5A5_0001, 5'd13, 3'd5, 32'h0000_0200, 0, 32'd0, 1'b0, 0, 1'b0);
    is_a_inst = 1'b1; mem_op = 5'b10010; result = 32'h1000_0030; rd = 5'd14; wb_src = 3'd1; pc = 32'h204;
    step();
    idle_inputs();
    step();
    chk("wait_before_rst", stall, 1'b1);
    rst = 1'b1; flush = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    step();
    chk("rstw_stall", stall, 1'b0);
    chk("rstw_wb_valid", wb_valid, 1'b0);
    chk("rstw_wb_rd", wb_rd, 5'd0);
    chk("rstw_wb_data", wb_data, 32'd0);
    chk("rstw_wb_src_out", wb_src_out, 3'd0);
    chk("rstw_pc_out", pc_out, 32'd0);
    chk("rstw_fault", fault, 1'b0);
    chk("rstw_fault_cause", fault_cause, 2'b00);
    rst = 1'b0;
    idle_inputs();
    dmem_rvalid = 1'b1;   // stray response after reset
    step();
    idle_inputs();
    chk("stray_rvalid_idle", stall, 1'b0);

    // Randomized mix
    for (int n = 0; n < 120; n++) begin
      t  = $urandom;
      a  = $urandom;
      if (t[3:2] != 2'b00) a[1:0] = 2'b00;
      op = (t[7:4] < 4'd3) ? {1'b0, t[11:8]} : {1'b1, t[11:8]};
      d  = $urandom_range(0, 5);
      fa = (t[14:12] == 3'd0) ? $urandom_range(1, d + 1) : 0;
      issue(op, a, t[19:15], t[22:20], $urandom, d, $urandom, (t[25:23] == 3'd0), fa, t[26]);
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (3) step();
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m2_mem_resp.md
M2_MEM_RESP -- requirements
Module: m2_mem_resp

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- is_a_inst  in  1  M2 slot holds a valid instruction
- mem_op  in  5  [4] mem access, [3] store(1)/load(0), [2] unsigned load, [1:0] size (00 B, 01 H, 10 W, 11 illegal)
- result  in  32  ALU result; effective address when mem_op[4]=1
- rd  in  5  destination register
- wb_src  in  3  writeback source select, passed through
- pc  in  32  instruction PC
- flush  in  1  kill the instruction in M2
- dmem_rvalid  in  1  data-memory response/ack strobe
- dmem_rdata  in  32  data-memory read word, valid with dmem_rvalid
- dmem_err  in  1  bus error, valid with dmem_rvalid
- stall  out  1  freeze upstream M1/M2 register
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  5  destination register
- wb_data  out  32  aligned load data or pass-through result
- wb_src_out  out  3  registered wb_src
- pc_out  out  32  registered pc
- fault  out  1  one-cycle exception strobe
- fault_cause  out  2  01 misaligned, 10 bus error, 11 timeout
REQ-002 One clock; rst SHALL be synchronous and active-high.

Function
REQ-003 FSM states SHALL be IDLE, WAIT, DRAIN; stall SHALL be combinational (state != IDLE).
REQ-004 Inputs SHALL be sampled only in IDLE with is_a_inst=1 and flush=0; they are ignored otherwise.
REQ-005 Non-memory op (mem_op[4]=0): next cycle wb_valid=1, wb_data=result, wb_rd=rd; state stays IDLE.
REQ-006 Misaligned access (H with result[0]=1, W with result[1:0]!=0, or size 11): next cycle fault=1, fault_cause=01, wb_valid=0; no memory wait.
REQ-007 Aligned load or store: capture rd, wb_src, pc, mem_op, result[1:0]; enter WAIT; clear the 8-bit wait counter.
REQ-008 In WAIT, dmem_rvalid SHALL be honoured from the cycle after capture; an rvalid in the capture cycle SHALL be ignored.
REQ-009 WAIT with dmem_rvalid=1, dmem_err=0: next cycle wb_valid=1 for loads, wb_valid=0 for stores; state goes to IDLE.
REQ-010 Load alignment: byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16]; word = rdata; sign-extend to 32 bits unless mem_op[2]=1.
REQ-011 WAIT with dmem_rvalid=1, dmem_err=1: next cycle fault=1, fault_cause=10, wb_valid=0; go to IDLE.
REQ-012 The wait counter SHALL increment each WAIT cycle without rvalid; at 255 the block SHALL pulse fault with cause 11, go to DRAIN, and never wrap.
REQ-013 flush in WAIT: go to DRAIN, no wb_valid or fault for that instruction; flush together with rvalid SHALL discard the response and go to IDLE.
REQ-014 DRAIN SHALL hold stall=1 until dmem_rvalid, discard that response, then return to IDLE.
REQ-015 wb_valid and fault SHALL be mutually exclusive single-cycle pulses; wb_rd, wb_data, wb_src_out, pc_out SHALL hold their last value otherwise.
REQ-016 wb_valid SHALL be suppressed when rd=0, but the transaction SHALL still complete.

Reset
REQ-017 rst=1 SHALL force state=IDLE, counter=0, and all outputs to 0 (stall=0) on the next edge, overriding any flush or rvalid.
REQ-018 rst in WAIT or DRAIN SHALL abandon the outstanding access; a later stray dmem_rvalid in IDLE SHALL be ignored.

Verification
REQ-019 ALU op, result=0x1234, rd=5 -> next cycle wb_valid=1, wb_data=0x1234, stall never set.
REQ-020 LB at result=0x..03, rvalid after 3 cycles, rdata=0x80FFFFFF -> stall=1 for 4 cycles, then wb_data=0xFFFFFF80; LBU gives 0x00000080.
REQ-021 LW at result=0x..02 -> fault=1, fault_cause=01, no stall, wb_valid=0.
REQ-022 LW, no rvalid for 255 cycles -> fault cause 11, then DRAIN; rvalid at cycle 300 -> back to IDLE, no wb_valid.
REQ-023 LH, flush in cycle 2 of WAIT, rvalid cycle 5 -> no wb_valid or fault, stall drops after rvalid.
REQ-024 SW ack with dmem_err=1 -> fault cause 10; rst asserted mid-WAIT -> all outputs 0 next cycle, state IDLE.
